// File: rtl/serial_adder_fsm.sv
// rtl/serial_adder_fsm.sv - bit-serial WIDTH-bit adder built from two cascaded half adders.
// Optional carry-in port and carry preload under SERIAL_ADD_CIN_EN.

module serial_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             ha0_s, ha0_c;
  logic             bit_s, ha1_c;
  logic             c_next;
  logic             c_init;

`ifdef SERIAL_ADD_CIN_EN
  assign c_init = cin;
`else
  assign c_init = 1'b0;
`endif

  serial_half_adder u_ha0 (
    .a_i (shift_a_q[0]),
    .b_i (shift_b_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  serial_half_adder u_ha1 (
    .a_i (ha0_s),
    .b_i (c_q),
    .s_o (bit_s),
    .c_o (ha1_c)
  );

  assign c_next = ha0_c | ha1_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    sum_d     = sum_q;
    carry_d   = carry_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_a_d = ip1;
          shift_b_d = ip2;
          res_d     = '0;
          cnt_d     = '0;
          c_d       = c_init;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Result fills from the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_d     = {bit_s, res_q[WIDTH-1:1]};
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        c_d       = c_next;
        if (cnt_q == LAST_BIT) begin
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          carry_d = c_next;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb/tb_serial_adder_fsm.sv - directed vector bench for serial_adder_fsm (WIDTH=8).
module tb_serial_adder_fsm;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] ip1;
  logic [W-1:0] ip2;
  logic         cin_r;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int n_total;
  int n_pass;

  logic [W-1:0] prev_sum;
  logic         prev_carry;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[$];

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ip1   (ip1),
    .ip2   (ip2),
`ifdef SERIAL_ADD_CIN_EN
    .cin   (cin_r),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One full add: start pulse, latency, busy length, result, result hold during RUN.
  task automatic run_add(input vec_t v, input string nm);
    int  lat;
    int  busy_n;
    bit  held;
    bit  got;
    ip1   = v.a;
    ip2   = v.b;
    cin_r = v.ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    ip1   = W'($urandom);
    ip2   = W'($urandom);
    cin_r = ~v.ci;
    busy_n = busy ? 1 : 0;
    held = 1'b1;
    got  = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (!done && (sum !== prev_sum || carry !== prev_carry)) held = 1'b0;
      tick();
      if (busy) busy_n++;
      if (done) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({nm, " latency"}, lat, W);
    chk({nm, " busy_cycles"}, busy_n, W + 1);
    chk({nm, " sum"}, sum, v.exp_sum);
    chk({nm, " carry"}, carry, v.exp_carry);
    chk({nm, " prev_held"}, held, 1);
    tick();
    chk({nm, " done_clear"}, done, 0);
    chk({nm, " busy_clear"}, busy, 0);
    chk({nm, " sum_stable"}, sum, v.exp_sum);
    prev_sum   = v.exp_sum;
    prev_carry = v.exp_carry;
  endtask

  initial begin
    vec_t v;
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    ip1   = '0;
    ip2   = '0;
    cin_r = 1'b0;
    prev_sum   = '0;
    prev_carry = 1'b0;

    vecs.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
`ifdef SERIAL_ADD_CIN_EN
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h10, 8'h20, 1'b1, 8'h31, 1'b0});
`endif

    tick();
    tick();
    chk("reset sum", sum, 0);
    chk("reset carry", carry, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("idle no start busy", busy, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_add(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high; operands change during RUN and must not be used
    ip1 = 8'h03;
    ip2 = 8'h04;
    cin_r = 1'b0;
    start = 1'b1;
    tick();
    chk("held start busy E0", busy, 1);
    ip1 = 8'hAA;
    ip2 = 8'h55;
    for (int k = 0; k < W; k++) tick();
    chk("held start done E8", done, 1);
    chk("held start sum", sum, 8'h07);
    chk("held start carry", carry, 0);
    tick();
    chk("held start idle E9", busy, 0);
    tick();
    chk("held start accepted E10", busy, 1);
    start = 1'b0;
    for (int k = 0; k < W; k++) tick();
    chk("second op done", done, 1);
    chk("second op sum", sum, 8'hFF);
    tick();

    // reset in the middle of RUN discards the operation
    ip1 = 8'h80;
    ip2 = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset sum", sum, 0);
    chk("async reset carry", carry, 0);
    chk("async reset busy", busy, 0);
    chk("async reset done", done, 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post-reset idle", busy, 0);
    tick();
    chk("post-reset no done", done, 0);
    prev_sum   = '0;
    prev_carry = 1'b0;
    v = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    run_add(v, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
